// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable instruction/data RAM:
// one-hot access-width codes and the lane decode used by reads and writes.
package mem_pkg;

  typedef logic [2:0] mem_mode_t;

  localparam mem_mode_t MODE_BYTE = 3'b001;
  localparam mem_mode_t MODE_HALF = 3'b010;
  localparam mem_mode_t MODE_WORD = 3'b100;

  // Little-endian lanes covered by an access; non-one-hot codes select nothing.
  function automatic logic [3:0] lane_enables(input mem_mode_t mode);
    logic [3:0] en;
    case (mode)
      MODE_BYTE: en = 4'b0001;
      MODE_HALF: en = 4'b0011;
      MODE_WORD: en = 4'b1111;
      default:   en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-addressable flop RAM with byte/half/word access, unaligned and
// wrapping lanes, synchronous writes and combinational zero-extended reads.
module instr_byte_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [7:0]       mem_d [DEPTH_BYTES];
  logic [3:0]       lane_en_s;
  logic [IDX_W-1:0] lane_idx_s [4];
  logic             unused_addr_s;

  // Upper address bits alias onto the same bytes.
  assign unused_addr_s = ^address[ADDR_W-1:IDX_W];

  // Lane decode: each lane index wraps naturally in IDX_W-bit arithmetic.
  always_comb begin
    lane_en_s = lane_enables(mem_mode_t'(mode));
    for (int k = 0; k < 4; k++) begin
      lane_idx_s[k] = address[IDX_W-1:0] + IDX_W'(k);
    end
  end

  // Next memory image: enabled lanes take write data, all other bytes hold.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 4; k++) begin
      mem_d[lane_idx_s[k]] = (we && lane_en_s[k]) ? wdata[8*k +: 8]
                                                  : mem_q[lane_idx_s[k]];
    end
  end

  // Read mux: disabled lanes (narrow or invalid modes) read as zero.
  always_comb begin
    rdata = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rdata[8*k +: 8] = lane_en_s[k] ? mem_q[lane_idx_s[k]] : 8'h00;
    end
  end

  // Storage: reset clears every byte asynchronously and overrides writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_instr_byte_ram.sv
// Self-checking bench for instr_byte_ram: directed plan followed by random
// traffic compared against a byte-array reference model.
module tb_instr_byte_ram;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  mode;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int n_checks;
  int n_fails;

  byte unsigned ref_mem [DEPTH];

  instr_byte_ram #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .mode    (mode),
    .address (address),
    .wdata   (wdata),
    .rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int width_of(input logic [2:0] m);
    case (m)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [2:0] m, input logic [31:0] a);
    logic [31:0] r;
    int base;
    r = 32'h0;
    base = int'(a % 32'(DEPTH));
    for (int k = 0; k < width_of(m); k++) begin
      r = r | (32'(ref_mem[(base + k) % DEPTH]) << (8 * k));
    end
    return r;
  endfunction

  task automatic ref_write(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    int base;
    base = int'(a % 32'(DEPTH));
    for (int k = 0; k < width_of(m); k++) begin
      ref_mem[(base + k) % DEPTH] = byte'((d >> (8 * k)) & 32'hFF);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // One clock cycle: drive, check pre-edge read against the model, apply edge.
  task automatic cyc(input logic w, input logic [2:0] m, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    we = w; mode = m; address = a; wdata = d;
    @(negedge clk);
    check_val(tag, rdata, ref_read(m, a));
    @(posedge clk);
    if (w && !rst) ref_write(m, a, d);
    #1;
  endtask

  // Read-only cycle checked against a bench-computed constant.
  task automatic rd(input logic [2:0] m, input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    we = 1'b0; mode = m; address = a; wdata = 32'h0;
    @(negedge clk);
    check_val(tag, rdata, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  m;
    logic [31:0] a;
    n_checks = 0;
    n_fails  = 0;
    ref_clear();
    rst = 1'b1; we = 1'b0; mode = 3'b100; address = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_held_word", rdata, 32'h0000_0000);
    rst = 1'b0;
    rd(3'b100, 32'h0, 32'h0000_0000, "reset_word0");

    cyc(1'b1, 3'b100, 32'h0, 32'h8765_4321, "ww0_pre");
    rd(3'b100, 32'h0, 32'h8765_4321, "word_rd0");
    rd(3'b010, 32'h0, 32'h0000_4321, "half_rd0");
    rd(3'b001, 32'h0, 32'h0000_0021, "byte_rd0");

    for (int i = 0; i < 4; i++) cyc(1'b1, 3'b001, 32'(i), 32'h98BA_DCFE, "bw_pre");
    rd(3'b100, 32'h0, 32'hFEFE_FEFE, "byte_fill");

    cyc(1'b1, 3'b010, 32'h2, 32'h2143_6587, "hw2_pre");
    rd(3'b100, 32'h0, 32'h6587_FEFE, "half_unal2");
    cyc(1'b1, 3'b010, 32'h0, 32'h2143_6587, "hw0_pre");
    rd(3'b100, 32'h0, 32'h6587_6587, "half_al0");

    cyc(1'b1, 3'b000, 32'h0, 32'h1234_5678, "inv000_rd");
    rd(3'b100, 32'h0, 32'h6587_6587, "inv000_keep");
    cyc(1'b1, 3'b011, 32'h0, 32'hCAFE_F00D, "inv011_rd");
    rd(3'b100, 32'h0, 32'h6587_6587, "inv011_keep");

    cyc(1'b1, 3'b100, 32'(DEPTH - 2), 32'hAABB_CCDD, "wrap_pre");
    rd(3'b001, 32'(DEPTH - 2), 32'h0000_00DD, "wrap_b254");
    rd(3'b001, 32'(DEPTH - 1), 32'h0000_00CC, "wrap_b255");
    rd(3'b001, 32'h0,          32'h0000_00BB, "wrap_b0");
    rd(3'b001, 32'h1,          32'h0000_00AA, "wrap_b1");
    rd(3'b100, 32'h0,          32'h6587_AABB, "word0_after_wrap");
    rd(3'b100, 32'(DEPTH),     32'h6587_AABB, "alias_depth");
    rd(3'b100, 32'hFFFF_FF00,  32'h6587_AABB, "alias_high");

    // Asynchronous reset between edges, then a write coinciding with reset.
    we = 1'b0; mode = 3'b100; address = 32'h0;
    #2;
    check_val("pre_rst_word", rdata, 32'h6587_AABB);
    rst = 1'b1;
    #1;
    check_val("rst_async", rdata, 32'h0000_0000);
    ref_clear();
    we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(3'b100, 32'h0, 32'h0000_0000, "rst_prio_word0");
    rd(3'b100, 32'(DEPTH - 2), 32'h0000_0000, "rst_clear_top");

    // Random traffic against the model; addresses biased to the top for wrap.
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 7))
        0:       m = 3'($urandom_range(0, 7));
        1, 2:    m = 3'b001;
        3, 4:    m = 3'b010;
        default: m = 3'b100;
      endcase
      a = $urandom();
      if ($urandom_range(0, 3) == 0) a[7:0] = 8'(DEPTH - 1 - $urandom_range(0, 3));
      cyc(1'($urandom_range(0, 1)), m, a, $urandom(), "rand");
    end
    for (int i = 0; i < DEPTH; i += 4) begin
      we = 1'b0; mode = 3'b100; address = 32'(i);
      @(negedge clk);
      check_val("final_sweep", rdata, ref_read(3'b100, 32'(i)));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
